pass_entry: RTL and testbench

//   Keypad/switch front end driving the door-lock FSM's passData/confirm inputs.

---
 rtl/pass_entry.sv | 160 ++++++++++++++++
 tb/tb_pass_entry.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pass_entry.sv
// pass_entry: debounced code-entry front end for the door-lock FSM.
// Ports: clk, rst (async, active-low), sw[3:0], btn, resOk, resBad
//        -> passData[3:0], confirm, busy, locked, failCnt[1:0].
module pass_entry #(
    parameter int DEB_CYCLES     = 4,
    parameter int RESP_TIMEOUT   = 8,
    parameter int MAX_FAIL       = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       btn,
    input  logic       resOk,
    input  logic       resBad,
    output logic [3:0] passData,
    output logic       confirm,
    output logic       busy,
    output logic       locked,
    output logic [1:0] failCnt
);
    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RES,
        LOCKOUT
    } state_t;

    localparam logic [7:0] DebMax   = 8'(DEB_CYCLES);
    localparam logic [7:0] RespLast = 8'(RESP_TIMEOUT - 1);
    localparam logic [7:0] LockLast = 8'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0] FailMax  = 3'(MAX_FAIL);

    state_t     state;
    state_t     stateNext;
    logic       btnMeta;
    logic       btnS;
    logic [1:0] syncValid;
    logic [7:0] deb;
    logic       armed;
    logic [7:0] tmr;
    logic       press;
    logic       timeout;
    logic       failEvt;
    logic [2:0] failInc;
    logic       lockHit;
    logic       lockDone;
    logic       confirmNext;
    logic       busyNext;
    logic       lockedNext;

    assign press    = armed && (deb == DebMax);
    assign timeout  = (tmr == RespLast);
    assign failEvt  = (state == WAIT_RES) &&
                      (resBad || (!resOk && timeout));
    assign failInc  = {1'b0, failCnt} + 3'd1;
    assign lockHit  = (failInc == FailMax);
    assign lockDone = (tmr == LockLast);

    // syncValid marks when btnS holds a real sample rather than its
    // reset value, so a button held through reset cannot arm itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btnMeta   <= 1'b0;
            btnS      <= 1'b0;
            syncValid <= 2'b00;
            deb       <= 8'd0;
            armed     <= 1'b0;
        end else begin
            btnMeta   <= btn;
            btnS      <= btnMeta;
            syncValid <= {syncValid[0], 1'b1};
            if (!btnS) begin
                deb <= 8'd0;
            end else if (deb != DebMax) begin
                deb <= deb + 8'd1;
            end
            if (syncValid[1] && !btnS) begin
                armed <= 1'b1;
            end else if (press) begin
                armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (press) begin
                    stateNext = SEND;
                end
            end
            SEND: begin
                stateNext = WAIT_RES;
            end
            WAIT_RES: begin
                if (failEvt) begin
                    stateNext = lockHit ? LOCKOUT : IDLE;
                end else if (resOk) begin
                    stateNext = IDLE;
                end
            end
            LOCKOUT: begin
                if (lockDone) begin
                    stateNext = IDLE;
                end
            end
        endcase
    end

    // Outputs are registered from the next state so they line up
    // with the state they describe.
    always_comb begin
        confirmNext = (stateNext == SEND);
        busyNext    = (stateNext == SEND) || (stateNext == WAIT_RES);
        lockedNext  = (stateNext == LOCKOUT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            passData <= 4'd0;
            confirm  <= 1'b0;
            busy     <= 1'b0;
            locked   <= 1'b0;
            failCnt  <= 2'd0;
            tmr      <= 8'd0;
        end else begin
            confirm <= confirmNext;
            busy    <= busyNext;
            locked  <= lockedNext;
            if (state == IDLE && press) begin
                passData <= sw;
            end
            if (failEvt) begin
                failCnt <= failInc[1:0];
            end else if (state == WAIT_RES && resOk) begin
                failCnt <= 2'd0;
            end else if (state == LOCKOUT && lockDone) begin
                failCnt <= 2'd0;
            end
            // One timer serves both the response timeout and the
            // lockout; it restarts on every state change.
            if (state == IDLE || stateNext != state) begin
                tmr <= 8'd0;
            end else begin
                tmr <= tmr + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pass_entry.sv
// tb_pass_entry: directed scenarios plus randomized run against
// a history-based reference model of the code-entry front end.
module tb_pass_entry;
    localparam int DEB = 4;
    localparam int RT  = 8;
    localparam int MF  = 3;
    localparam int LC  = 16;
    localparam int LAT = 2 + DEB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       btn = 1'b0;
    logic       resOk = 1'b0;
    logic       resBad = 1'b0;
    logic [3:0] passData;
    logic       confirm;
    logic       busy;
    logic       locked;
    logic [1:0] failCnt;
    logic [8:0] dutVec;

    int checks = 0;
    int errors = 0;

    pass_entry #(
        .DEB_CYCLES(DEB),
        .RESP_TIMEOUT(RT),
        .MAX_FAIL(MF),
        .LOCKOUT_CYCLES(LC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .btn(btn),
        .resOk(resOk),
        .resBad(resBad),
        .passData(passData),
        .confirm(confirm),
        .busy(busy),
        .locked(locked),
        .failCnt(failCnt)
    );

    assign dutVec = {passData, confirm, busy, locked, failCnt};

    always #5 clk = ~clk;

    // Reference model: raw[k] is btn as seen at the (k+1)th edge
    // after reset. Mode 0 idle, 1 send, 2 wait, 3 lockout.
    int raw[$];
    int mMode;
    int mWait;
    int mLock;
    int mFail;
    int mData;
    bit mArmed;
    bit mPress;

    function automatic int runRaw(int i);
        int c;
        int j;
        c = 0;
        j = i;
        while (j >= 0 && c < DEB && raw[j] == 1) begin
            c++;
            j--;
        end
        return c;
    endfunction

    function automatic void modelReset();
        raw.delete();
        mMode = 0;
        mWait = 0;
        mLock = 0;
        mFail = 0;
        mData = 0;
        mArmed = 1'b0;
        mPress = 1'b0;
    endfunction

    function automatic void modelStep();
        int n;
        bit pp;
        raw.push_back(int'(btn));
        n = raw.size();
        pp = mPress;
        case (mMode)
            0: begin
                if (pp) begin
                    mData = int'(sw);
                    mMode = 1;
                end
            end
            1: begin
                mMode = 2;
                mWait = 0;
            end
            2: begin
                if (resBad || (!resOk && mWait + 1 == RT)) begin
                    if (mFail + 1 == MF) begin
                        mFail = MF;
                        mMode = 3;
                        mLock = 0;
                    end else begin
                        mFail++;
                        mMode = 0;
                    end
                end else if (resOk) begin
                    mFail = 0;
                    mMode = 0;
                end else begin
                    mWait++;
                end
            end
            default: begin
                mLock++;
                if (mLock == LC) begin
                    mFail = 0;
                    mMode = 0;
                end
            end
        endcase
        if (n >= 3 && raw[n-3] == 0) begin
            mArmed = 1'b1;
        end else if (pp) begin
            mArmed = 1'b0;
        end
        mPress = mArmed && (runRaw(n - 3) >= DEB);
    endfunction

    function automatic logic [8:0] expVec();
        return {4'(mData), mMode == 1, mMode == 1 || mMode == 2,
                mMode == 3, 2'(mFail)};
    endfunction

    task automatic tick();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic pressBtn(input logic [3:0] code, output int lat);
        btn = 1'b0;
        repeat (3) tick();
        sw = code;
        btn = 1'b1;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (confirm) begin
                lat = i;
                break;
            end
        end
        btn = 1'b0;
    endtask

    task automatic test_reset();
        int nConf;
        checks++;
        if (dutVec !== 9'd0) begin
            errors++;
            $display("FAIL reset_outs got %h want 000", dutVec);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        modelReset();
        nConf = 0;
        repeat (10) begin
            tick();
            if (confirm) nConf++;
        end
        checks++;
        if (nConf !== 0 || dutVec !== 9'd0) begin
            errors++;
            $display("FAIL reset_idle got conf=%0d vec=%h want 0/000",
                     nConf, dutVec);
        end
    endtask

    task automatic test_basic();
        int lat;
        int nConf;
        logic [3:0] dAt;
        logic bAt;
        sw = 4'd9;
        btn = 1'b1;
        lat = -1;
        nConf = 0;
        dAt = 4'd0;
        bAt = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (confirm) begin
                nConf++;
                if (lat < 0) lat = i;
                dAt = passData;
                bAt = busy;
            end
        end
        btn = 1'b0;
        tick();
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL basic_lat got %0d want %0d", lat, LAT);
        end
        checks++;
        if (nConf !== 1) begin
            errors++;
            $display("FAIL basic_count got %0d want 1", nConf);
        end
        checks++;
        if (dAt !== 4'd9 || bAt !== 1'b1) begin
            errors++;
            $display("FAIL basic_data got %0d/%0b want 9/1", dAt, bAt);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_wait_busy got %0b want 1", busy);
        end
        resOk = 1'b1;
        tick();
        resOk = 1'b0;
        checks++;
        if ({busy, failCnt, passData} !== {1'b0, 2'd0, 4'd9}) begin
            errors++;
            $display("FAIL basic_ok got b%0b f%0d d%0d want b0 f0 d9",
                     busy, failCnt, passData);
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        int bConf;
        int nConf;
        int lat;
        pat = 5'b01101;
        bConf = 0;
        nConf = 0;
        lat = -1;
        btn = 1'b0;
        repeat (3) tick();
        sw = 4'd5;
        for (int i = 0; i < 5; i++) begin
            btn = pat[i];
            tick();
            if (confirm) bConf++;
        end
        btn = 1'b1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            resOk = 1'b0;
            if (confirm) begin
                nConf++;
                if (lat < 0) lat = i;
            end
            if (lat > 0 && i == lat + 2) resOk = 1'b1;
        end
        resOk = 1'b0;
        btn = 1'b0;
        checks++;
        if (bConf !== 0) begin
            errors++;
            $display("FAIL bounce_quiet got %0d want 0", bConf);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL bounce_lat got %0d want %0d", lat, LAT);
        end
        checks++;
        if (nConf !== 1 || failCnt !== 2'd0) begin
            errors++;
            $display("FAIL bounce_hold got %0d/%0d want 1/0",
                     nConf, failCnt);
        end
    endtask

    task automatic test_lockout();
        int lat;
        int lockCnt;
        int guard;
        int nConf;
        for (int k = 1; k <= MF; k++) begin
            pressBtn(4'(k), lat);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL lock_press%0d got %0d want %0d",
                         k, lat, LAT);
            end
            tick();
            tick();
            resBad = 1'b1;
            tick();
            resBad = 1'b0;
            checks++;
            if (failCnt !== 2'(k) || locked !== (k == MF)) begin
                errors++;
                $display("FAIL lock_fail%0d got f%0d l%0b want f%0d l%0b",
                         k, failCnt, locked, k, k == MF);
            end
        end
        lockCnt = 1;
        guard = 0;
        nConf = 0;
        btn = 1'b1;
        while (locked && guard < 40) begin
            tick();
            guard++;
            if (guard == 8) btn = 1'b0;
            if (confirm) nConf++;
            if (locked) lockCnt++;
        end
        btn = 1'b0;
        repeat (10) begin
            tick();
            if (confirm) nConf++;
        end
        checks++;
        if (lockCnt !== LC) begin
            errors++;
            $display("FAIL lock_len got %0d want %0d", lockCnt, LC);
        end
        checks++;
        if (nConf !== 0) begin
            errors++;
            $display("FAIL lock_discard got %0d want 0", nConf);
        end
        checks++;
        if (failCnt !== 2'd0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_exit got f%0d l%0b want f0 l0",
                     failCnt, locked);
        end
    endtask

    task automatic test_timeout();
        int lat;
        int n;
        pressBtn(4'hC, lat);
        n = 0;
        while (busy && n < 30) begin
            tick();
            n++;
        end
        checks++;
        if (n !== RT + 1) begin
            errors++;
            $display("FAIL timeout_len got %0d want %0d", n, RT + 1);
        end
        checks++;
        if (failCnt !== 2'd1 || passData !== 4'hC) begin
            errors++;
            $display("FAIL timeout_fail got f%0d d%0h want f1 dC",
                     failCnt, passData);
        end
    endtask

    task automatic test_simul();
        int lat;
        pressBtn(4'h3, lat);
        tick();
        resOk = 1'b1;
        resBad = 1'b1;
        tick();
        resOk = 1'b0;
        resBad = 1'b0;
        checks++;
        if (failCnt !== 2'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL simul_bad_wins got f%0d b%0b want f2 b0",
                     failCnt, busy);
        end
    endtask

    task automatic test_recover();
        int lat;
        pressBtn(4'h7, lat);
        tick();
        resOk = 1'b1;
        tick();
        resOk = 1'b0;
        checks++;
        if (failCnt !== 2'd0) begin
            errors++;
            $display("FAIL recover_clear got %0d want 0", failCnt);
        end
        for (int k = 1; k <= 2; k++) begin
            pressBtn(4'hE, lat);
            tick();
            resBad = 1'b1;
            tick();
            resBad = 1'b0;
            checks++;
            if (failCnt !== 2'(k) || locked !== 1'b0) begin
                errors++;
                $display("FAIL recover_fail%0d got f%0d l%0b want f%0d l0",
                         k, failCnt, locked, k);
            end
        end
        pressBtn(4'h1, lat);
        tick();
        resOk = 1'b1;
        tick();
        resOk = 1'b0;
    endtask

    task automatic test_reset_wait();
        int lat;
        int nConf;
        pressBtn(4'h6, lat);
        tick();
        tick();
        btn = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dutVec !== 9'd0) begin
            errors++;
            $display("FAIL rstwait_outs got %h want 000", dutVec);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        modelReset();
        nConf = 0;
        repeat (25) begin
            tick();
            if (confirm) nConf++;
        end
        checks++;
        if (nConf !== 0) begin
            errors++;
            $display("FAIL rstwait_held got %0d want 0", nConf);
        end
        pressBtn(4'hA, lat);
        checks++;
        if (lat !== LAT || passData !== 4'hA) begin
            errors++;
            $display("FAIL rstwait_repress got l%0d d%0h want l%0d dA",
                     lat, passData, LAT);
        end
        tick();
        resOk = 1'b1;
        tick();
        resOk = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            sw = 4'($urandom);
            resOk = ($urandom_range(0, 9) == 0);
            resBad = ($urandom_range(0, 13) == 0);
            if (i == 1000) begin
                #2 rst = 1'b0;
                #1;
                checks++;
                if (dutVec !== 9'd0) begin
                    errors++;
                    $display("FAIL rand_rst got %h want 000", dutVec);
                end
                @(posedge clk);
                #1 rst = 1'b1;
                modelReset();
            end
            tick();
            checks++;
            if (dutVec !== expVec()) begin
                errors++;
                $display("FAIL rand_cycle%0d got %h want %h",
                         i, dutVec, expVec());
            end
        end
        btn = 1'b0;
        resOk = 1'b0;
        resBad = 1'b0;
    endtask

    initial begin
        modelReset();
        #3;
        test_reset();
        test_basic();
        test_bounce();
        test_lockout();
        test_timeout();
        test_simul();
        test_recover();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
